// File: rtl/uart_rx_framed_if.sv
// Receive-side word handshake: word plus per-word error flags, valid/ready flow control.
interface uart_rx_framed_if #(
  parameter int unsigned DataBits = 8
);
  logic [DataBits-1:0] data;
  logic                valid;
  logic                ready;
  logic                parity_err;
  logic                frame_err;

  modport master (output data, valid, parity_err, frame_err, input ready);
  modport slave  (input data, valid, parity_err, frame_err, output ready);
endinterface

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with false-start rejection, parity/framing checks and overrun flag.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_framed #(
  parameter int unsigned DataBits     = 8,
  parameter int unsigned Oversample   = 16,
  parameter int unsigned ParityMode   = 0,
  parameter int unsigned StopBitTicks = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  input  logic                sample_tick_i,
  uart_rx_framed_if.master    rx_bus,
  output logic                overrun_o,
  output logic                break_o,
  output logic                busy_o
);

  localparam int unsigned TcMax = (Oversample > StopBitTicks) ? Oversample : StopBitTicks;
  localparam int unsigned TcW   = $clog2(TcMax);
  localparam int unsigned BcW   = $clog2(DataBits);

  localparam logic [TcW-1:0] HalfLast = TcW'(Oversample / 2 - 1);
  localparam logic [TcW-1:0] BitLast  = TcW'(Oversample - 1);
  localparam logic [TcW-1:0] StopLast = TcW'(StopBitTicks - 1);
  localparam logic [BcW-1:0] LastBit  = BcW'(DataBits - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic                rxs;
  logic [TcW-1:0]      tc_q, tc_d;
  logic [BcW-1:0]      bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                perr_q, perr_d;
  logic                pbit_q, pbit_d;
  logic                done, ferr, brk;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[0], rx_i};
  end
  assign rxs = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tc_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      pbit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      pbit_q  <= pbit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    pbit_d  = pbit_q;
    done    = 1'b0;
    ferr    = 1'b0;
    brk     = 1'b0;
    case (state_q)
      IDLE: if (!rxs) begin
        state_d = START;
        tc_d    = '0;
      end
      START: if (sample_tick_i) begin
        if (tc_q == HalfLast) begin
          state_d = rxs ? IDLE : DATA;
          tc_d    = '0;
          bit_d   = '0;
        end else tc_d = tc_q + TcW'(1);
      end
      DATA: if (sample_tick_i) begin
        if (tc_q == BitLast) begin
          shift_d = {rxs, shift_q[DataBits-1:1]};
          tc_d    = '0;
          if (bit_q == LastBit) state_d = (ParityMode != 0) ? PARITY : STOP;
          else                  bit_d   = bit_q + BcW'(1);
        end else tc_d = tc_q + TcW'(1);
      end
      PARITY: if (sample_tick_i) begin
        if (tc_q == BitLast) begin
          pbit_d  = rxs;
          perr_d  = (ParityMode == 1) ? (^shift_q ^ rxs) : ~(^shift_q ^ rxs);
          state_d = STOP;
          tc_d    = '0;
        end else tc_d = tc_q + TcW'(1);
      end
      STOP: if (sample_tick_i) begin
        if (tc_q == StopLast) begin
          done    = 1'b1;
          ferr    = ~rxs;
          state_d = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
          brk = (shift_q == '0) && !rxs && ((ParityMode == 0) || !pbit_q);
          if (brk) state_d = BRK;
`endif
        end else tc_d = tc_q + TcW'(1);
      end
      BRK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A completing frame may load in the same cycle the held word is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_bus.data       <= '0;
      rx_bus.valid      <= 1'b0;
      rx_bus.parity_err <= 1'b0;
      rx_bus.frame_err  <= 1'b0;
      overrun_o         <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done && !brk) begin
        if (!rx_bus.valid || rx_bus.ready) begin
          rx_bus.data       <= shift_q;
          rx_bus.parity_err <= perr_q;
          rx_bus.frame_err  <= ferr;
          rx_bus.valid      <= 1'b1;
        end else overrun_o <= 1'b1;
      end else if (rx_bus.valid && rx_bus.ready) begin
        rx_bus.valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) brk_q <= 1'b0;
    else       brk_q <= done && brk;
  end
  assign break_o = brk_q;
`else
  assign break_o = 1'b0;
`endif

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Randomised self-checking bench for uart_rx_framed: default instance plus an even-parity instance.
module tb_uart_rx_framed;
  localparam int OS = 16;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, rx0 = 1'b1, rx1 = 1'b1;
  logic ovr0, brk0, busy0, ovr1, brk1, busy1;
  int   checks = 0, errors = 0;
  int   vcyc0 = 0, ovr_cnt0 = 0, brk_cnt0 = 0;
  rec_t got0[$], got1[$];

  uart_rx_framed_if #(.DataBits(8)) bus0 ();
  uart_rx_framed_if #(.DataBits(8)) bus1 ();

  uart_rx_framed #(.DataBits(8), .Oversample(OS), .ParityMode(0), .StopBitTicks(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx0), .sample_tick_i(tick), .rx_bus(bus0),
    .overrun_o(ovr0), .break_o(brk0), .busy_o(busy0));

  uart_rx_framed #(.DataBits(8), .Oversample(OS), .ParityMode(1), .StopBitTicks(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .rx_i(rx1), .sample_tick_i(tick), .rx_bus(bus1),
    .overrun_o(ovr1), .break_o(brk1), .busy_o(busy1));

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (2) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus0.valid) vcyc0++;
    if (ovr0) ovr_cnt0++;
    if (brk0) brk_cnt0++;
    if (bus0.valid && bus0.ready) got0.push_back('{bus0.data, bus0.parity_err, bus0.frame_err});
    if (bus1.valid && bus1.ready) got1.push_back('{bus1.data, bus1.parity_err, bus1.frame_err});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick);
    end
    #1;
  endtask

  task automatic set_rx(input int ch, input logic v);
    if (ch == 0) rx0 = v;
    else         rx1 = v;
  endtask

  task automatic send(input int ch, input logic [7:0] d, input bit par_en, input logic pbit,
                      input logic stop, input int idle_after);
    set_rx(ch, 1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      set_rx(ch, d[i]);
      wait_ticks(OS);
    end
    if (par_en) begin
      set_rx(ch, pbit);
      wait_ticks(OS);
    end
    set_rx(ch, stop);
    wait_ticks(OS);
    set_rx(ch, 1'b1);
    wait_ticks(idle_after);
  endtask

  // Reference: even parity flags an error when data plus parity bit holds an odd count of ones.
  function automatic logic exp_perr(input int ch, input logic [7:0] d, input logic pbit);
    if (ch == 0) return 1'b0;
    return ($countones({d, pbit}) % 2) != 0;
  endfunction

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus0.data !== 8'h00)    begin errors++; $display("FAIL reset_data got %h exp 00", bus0.data); end
    checks++; if (bus0.valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b exp 0", bus0.valid); end
    checks++; if (bus0.parity_err !== 1'b0 || bus0.frame_err !== 1'b0)
                begin errors++; $display("FAIL reset_errs got %b%b exp 00", bus0.parity_err, bus0.frame_err); end
    checks++; if (ovr0 !== 1'b0 || brk0 !== 1'b0)
                begin errors++; $display("FAIL reset_pulses got %b%b exp 00", ovr0, brk0); end
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0)
                begin errors++; $display("FAIL reset_busy got %b%b exp 00", busy0, busy1); end
    rst = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_basic();
    int n = got0.size();
    int v = vcyc0;
    bus0.ready = 1'b1;
    send(0, 8'hA5, 0, 1'b0, 1'b1, 4);
    checks++; if (got0.size() !== n + 1) begin errors++; $display("FAIL basic_count got %0d exp %0d", got0.size(), n + 1); end
    if (got0.size() > n) begin
      checks++; if (got0[n].d !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", got0[n].d); end
      checks++; if (got0[n].pe !== 1'b0 || got0[n].fe !== 1'b0)
                  begin errors++; $display("FAIL basic_errs got %b%b exp 00", got0[n].pe, got0[n].fe); end
    end
    checks++; if (vcyc0 - v !== 1) begin errors++; $display("FAIL basic_valid_width got %0d exp 1", vcyc0 - v); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy0); end
  endtask

  task automatic test_parity();
    logic pb;
    for (int k = 0; k < 2; k++) begin
      int n = got1.size();
      pb = (k == 1);
      send(1, 8'h07, 1, pb, 1'b1, 4);
      checks++; if (got1.size() !== n + 1) begin errors++; $display("FAIL parity_count got %0d exp %0d", got1.size(), n + 1); end
      if (got1.size() > n) begin
        checks++; if (got1[n].d !== 8'h07) begin errors++; $display("FAIL parity_data got %h exp 07", got1[n].d); end
        checks++; if (got1[n].pe !== exp_perr(1, 8'h07, pb))
                    begin errors++; $display("FAIL parity_err pbit %b got %b exp %b", pb, got1[n].pe, exp_perr(1, 8'h07, pb)); end
      end
    end
  endtask

  task automatic test_glitch();
    int n = got0.size();
    int v = vcyc0;
    rx0 = 1'b0;
    wait_ticks(5);
    rx0 = 1'b1;
    wait_ticks(20);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy0); end
    checks++; if (vcyc0 !== v) begin errors++; $display("FAIL glitch_valid got %0d cycles exp 0", vcyc0 - v); end
    send(0, 8'h3C, 0, 1'b0, 1'b1, 4);
    checks++; if (got0.size() !== n + 1) begin errors++; $display("FAIL glitch_count got %0d exp %0d", got0.size(), n + 1); end
    if (got0.size() > n) begin
      checks++; if (got0[n].d !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got %h exp 3c", got0[n].d); end
    end
  endtask

  task automatic test_overrun();
    int n = got0.size();
    int o = ovr_cnt0;
    bus0.ready = 1'b0;
    send(0, 8'h11, 0, 1'b0, 1'b1, 4);
    send(0, 8'h22, 0, 1'b0, 1'b1, 4);
    checks++; if (ovr_cnt0 - o !== 1) begin errors++; $display("FAIL overrun_pulses got %0d exp 1", ovr_cnt0 - o); end
    checks++; if (bus0.valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got %b exp 1", bus0.valid); end
    checks++; if (bus0.data !== 8'h11) begin errors++; $display("FAIL overrun_held got %h exp 11", bus0.data); end
    bus0.ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus0.valid !== 1'b0) begin errors++; $display("FAIL overrun_accept_valid got %b exp 0", bus0.valid); end
    checks++; if (got0.size() !== n + 1) begin errors++; $display("FAIL overrun_count got %0d exp %0d", got0.size(), n + 1); end
    if (got0.size() > n) begin
      checks++; if (got0[n].d !== 8'h11) begin errors++; $display("FAIL overrun_accept_data got %h exp 11", got0[n].d); end
    end
  endtask

  task automatic test_frame_err();
    int n = got0.size();
    send(0, 8'h55, 0, 1'b0, 1'b0, 4);
    checks++; if (got0.size() !== n + 1) begin errors++; $display("FAIL ferr_count got %0d exp %0d", got0.size(), n + 1); end
    if (got0.size() > n) begin
      checks++; if (got0[n].d !== 8'h55 || got0[n].fe !== 1'b1)
                  begin errors++; $display("FAIL ferr_word got %h/%b exp 55/1", got0[n].d, got0[n].fe); end
    end
  endtask

  task automatic test_back_to_back();
    int n = got0.size();
    logic [7:0] exp[3];
    for (int k = 0; k < 3; k++) begin
      exp[k] = 8'($urandom);
      send(0, exp[k], 0, 1'b0, 1'b1, 0);
    end
    wait_ticks(4);
    checks++; if (got0.size() !== n + 3) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got0.size(), n + 3); end
    for (int k = 0; k < 3; k++) begin
      if (got0.size() > n + k) begin
        checks++; if (got0[n + k].d !== exp[k] || got0[n + k].fe !== 1'b0)
                    begin errors++; $display("FAIL b2b_word%0d got %h/%b exp %h/0", k, got0[n + k].d, got0[n + k].fe, exp[k]); end
      end
    end
  endtask

  task automatic test_random();
    int b = brk_cnt0;
    for (int k = 0; k < 12; k++) begin
      int ch = int'($urandom_range(1, 0));
      logic [7:0] d = 8'($urandom);
      logic pb = 1'($urandom);
      logic st = ($urandom_range(2, 0) != 0);
      int n = (ch == 0) ? got0.size() : got1.size();
      rec_t r;
      if (!st && d == 8'h00) d = 8'h01;
      send(ch, d, ch == 1, pb, st, int'($urandom_range(20, 0)));
      wait_ticks(1);
      checks++;
      if (((ch == 0) ? got0.size() : got1.size()) !== n + 1) begin
        errors++; $display("FAIL rand_count ch%0d frame %0d missing", ch, k);
      end else begin
        r = (ch == 0) ? got0[n] : got1[n];
        if (r.d !== d || r.pe !== exp_perr(ch, d, pb) || r.fe !== !st) begin
          errors++;
          $display("FAIL rand_word ch%0d got %h/%b/%b exp %h/%b/%b", ch, r.d, r.pe, r.fe, d, exp_perr(ch, d, pb), !st);
        end
      end
    end
`ifndef UART_RX_BREAK_DETECT_EN
    checks++; if (brk_cnt0 !== b) begin errors++; $display("FAIL rand_break got %0d pulses exp 0", brk_cnt0 - b); end
`endif
  endtask

`ifdef UART_RX_BREAK_DETECT_EN
  task automatic test_break();
    int b = brk_cnt0;
    int v = vcyc0;
    rx0 = 1'b0;
    wait_ticks(12 * OS);
    checks++; if (brk_cnt0 - b !== 1) begin errors++; $display("FAIL break_pulse got %0d exp 1", brk_cnt0 - b); end
    checks++; if (vcyc0 !== v) begin errors++; $display("FAIL break_valid got %0d cycles exp 0", vcyc0 - v); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL break_busy got %b exp 1", busy0); end
    rx0 = 1'b1;
    wait_ticks(2);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL break_release got %b exp 0", busy0); end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    send(0, 8'h5A, 0, 1'b0, 1'b1, 2);
    rx0 = 1'b0;
    wait_ticks(OS);
    rx0 = 1'b1;
    wait_ticks(3 * OS);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy0); end
    rst = 1'b1;
    #1;
    checks++; if (bus0.data !== 8'h00 || bus0.valid !== 1'b0 || busy0 !== 1'b0 || bus0.frame_err !== 1'b0)
                begin errors++; $display("FAIL midrst_outputs got %h/%b/%b/%b exp 00/0/0/0", bus0.data, bus0.valid, busy0, bus0.frame_err); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n = got0.size();
    wait_ticks(4);
    send(0, 8'hC3, 0, 1'b0, 1'b1, 4);
    checks++; if (got0.size() !== n + 1) begin errors++; $display("FAIL midrst_count got %0d exp %0d", got0.size(), n + 1); end
    if (got0.size() > n) begin
      checks++; if (got0[n].d !== 8'hC3 || got0[n].fe !== 1'b0)
                  begin errors++; $display("FAIL midrst_word got %h/%b exp c3/0", got0[n].d, got0[n].fe); end
    end
  endtask

  initial begin
    bus0.ready = 1'b1;
    bus1.ready = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_back_to_back();
    test_random();
`ifdef UART_RX_BREAK_DETECT_EN
    test_break();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
